// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer for an 8-bit, 8-register machine: fetch, decode, execute
// against an external ALU, and write back into an external register file.
module instr_sequencer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic [2:0] rf_raddr_a,
    output logic [2:0] rf_raddr_b,
    input  logic [7:0] rf_rdata_a,
    input  logic [7:0] rf_rdata_b,
    output logic [1:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_y,
    output logic       rf_we,
    output logic [2:0] rf_waddr,
    output logic [7:0] rf_wdata,
    output logic [7:0] pc,
    output logic [2:0] state,
    output logic       flag_zero,
    output logic       halted,
    output logic       fault,
    output logic       busy
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_WB2    = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    state_t        st, st_nxt;
    logic [7:0]    pc_r, ir, opa, opb, res, exec_res;
    logic [CW-1:0] wait_cnt;
    logic          flag_zero_r, fault_r;
    logic [1:0]    opcode;
    logic [2:0]    ra, rb;
    logic          is_halt, is_nop, is_swap, is_clr, ack_expired;

    assign opcode      = ir[7:6];
    assign ra          = ir[5:3];
    assign rb          = ir[2:0];
    assign is_halt     = (opcode == 2'b00) && (rb == 3'b000);
    assign is_nop      = (opcode == 2'b00) && rb[2];
    assign is_clr      = (opcode == 2'b00) && (rb == 3'b011);
    assign is_swap     = (opcode == 2'b11);
    assign ack_expired = (wait_cnt == CW'(ACK_TIMEOUT - 1));

    always_comb begin
        st_nxt = st;
        case (st)
            S_IDLE:   if (start) st_nxt = S_FETCH;
            S_FETCH:  if (imem_ack) st_nxt = S_DECODE;
                      else if (ack_expired) st_nxt = S_HALT;
            S_DECODE: st_nxt = is_halt ? S_HALT : (is_nop ? S_FETCH : S_EXEC);
            S_EXEC:   st_nxt = S_WB;
            S_WB:     st_nxt = is_swap ? S_WB2 : S_FETCH;
            S_WB2:    st_nxt = S_FETCH;
            S_HALT:   if (start) st_nxt = S_FETCH;
            default:  st_nxt = S_IDLE;
        endcase
    end

    // ALU is only driven for the four arithmetic ops; CLR/SWAP bypass it.
    always_comb begin
        alu_op = 2'b00;
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        if (st == S_EXEC) begin
            case (opcode)
                2'b01: begin alu_op = 2'b00; alu_a = opa; alu_b = opb; end
                2'b10: begin alu_op = 2'b01; alu_a = opa; alu_b = opb; end
                2'b00: begin
                    if (rb == 3'b001) begin alu_op = 2'b00; alu_a = opa; alu_b = 8'h01; end
                    if (rb == 3'b010) begin alu_op = 2'b01; alu_a = opa; alu_b = 8'h01; end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        exec_res = alu_y;
        if (is_swap)     exec_res = opb;
        else if (is_clr) exec_res = 8'h00;
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 3'd0;
        rf_wdata = 8'h00;
        if (st == S_WB) begin
            rf_we = 1'b1; rf_waddr = ra; rf_wdata = res;
        end else if (st == S_WB2) begin
            rf_we = 1'b1; rf_waddr = rb; rf_wdata = opa;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_IDLE;
            pc_r        <= 8'h00;
            ir          <= 8'h00;
            opa         <= 8'h00;
            opb         <= 8'h00;
            res         <= 8'h00;
            wait_cnt    <= '0;
            flag_zero_r <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            st <= st_nxt;
            case (st)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_data;
                        pc_r     <= pc_r + 8'h01;
                        wait_cnt <= '0;
                    end else if (ack_expired) begin
                        fault_r  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_DECODE: begin
                    opa <= rf_rdata_a;
                    opb <= rf_rdata_b;
                end
                S_EXEC:  res <= exec_res;
                S_WB:    flag_zero_r <= (res == 8'h00);
                S_HALT:  if (start) fault_r <= 1'b0;
                default: ;
            endcase
        end
    end

    assign imem_req   = (st == S_FETCH);
    assign imem_addr  = pc_r;
    assign rf_raddr_a = ra;
    assign rf_raddr_b = rb;
    assign pc         = pc_r;
    assign state      = st;
    assign flag_zero  = flag_zero_r;
    assign fault      = fault_r;
    assign halted     = (st == S_HALT);
    assign busy       = (st != S_IDLE) && (st != S_HALT);
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: behavioural imem, register file and ALU
// around the DUT, with hand-computed expectations per cycle.
module tb_instr_sequencer;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       imem_req, imem_ack;
    logic [7:0] imem_addr, imem_data;
    logic [2:0] rf_raddr_a, rf_raddr_b, rf_waddr, state;
    logic [7:0] rf_rdata_a, rf_rdata_b, alu_a, alu_b, alu_y, rf_wdata, pc;
    logic [1:0] alu_op;
    logic       rf_we, flag_zero, halted, fault, busy;

    logic [7:0] imem [256];
    logic [7:0] rf [8];
    logic       ack_en;
    logic       pre_we;
    logic [2:0] pre_addr;
    logic [7:0] pre_data;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    assign imem_ack   = imem_req & ack_en;
    assign imem_data  = imem[imem_addr];
    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];
    assign alu_y      = alu_op[0] ? (alu_a - alu_b) : (alu_a + alu_b);

    always @(posedge clk) begin
        if (pre_we)     rf[pre_addr] <= pre_data;
        else if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    instr_sequencer #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc(pc), .state(state), .flag_zero(flag_zero),
        .halted(halted), .fault(fault), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic set_reg(input logic [2:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int k = 0;
        while (state != 3'd6 && k < budget) begin
            step();
            k++;
        end
        chk(tag, state, 3'd6);
    endtask

    initial begin
        imem[0] = 8'h41;  // ADD r0,r1
        imem[1] = 8'h00;  // HALT
        imem[2] = 8'h92;  // SUB r2,r2
        imem[3] = 8'h1A;  // DEC r3
        imem[4] = 8'h19;  // INC r3
        imem[5] = 8'h00;
        imem[6] = 8'hCA;  // SWAP r1,r2
        imem[7] = 8'h04;  // NOP
        imem[8] = 8'h00;
        imem[9] = 8'h00;
        for (int i = 10; i < 255; i++) imem[i] = 8'h04;
        imem[255] = 8'h00;

        rst = 1'b1; start = 1'b0; ack_en = 1'b1; pre_we = 1'b0;
        pre_addr = 3'd0; pre_data = 8'h00;
        set_reg(3'd0, 8'd5);
        set_reg(3'd1, 8'd3);
        set_reg(3'd2, 8'd7);
        set_reg(3'd3, 8'd0);
        chk("rst_state", state, 3'd0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_outs", {imem_req, rf_we, alu_op, alu_a, alu_b, rf_waddr, rf_wdata}, 32'h0);
        chk("rst_flags", {flag_zero, halted, fault}, 3'b000);
        rst = 1'b0;
        step();
        chk("idle_hold", state, 3'd0);

        // ADD r0,r1: 5+3
        pulse_start();
        chk("add_fetch", {imem_req, imem_addr, busy}, {1'b1, 8'h00, 1'b1});
        step();
        chk("add_decode", {state, pc}, {3'd2, 8'h01});
        step();
        chk("add_exec", {alu_op, alu_a, alu_b}, {2'b00, 8'd5, 8'd3});
        step();
        chk("add_wb", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd0, 8'd8});
        step();
        chk("add_after", {state, rf_we, flag_zero, rf[0]}, {3'd1, 1'b0, 1'b0, 8'd8});
        chk("add_alu_idle", {alu_op, alu_a, alu_b}, 18'h0);
        step(2);
        chk("halt1", {state, halted, busy, pc}, {3'd6, 1'b1, 1'b0, 8'd2});

        // SUB r2,r2 -> 0; DEC r3 -> FF; INC r3 -> 00
        pulse_start();
        chk("sub_fetch", {state, imem_addr, halted, fault}, {3'd1, 8'd2, 1'b0, 1'b0});
        step(3);
        chk("sub_wb", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd2, 8'h00});
        step();
        chk("sub_zero", flag_zero, 1'b1);
        step(2);
        chk("dec_exec", {alu_op, alu_a, alu_b}, {2'b01, 8'h00, 8'h01});
        step();
        chk("dec_wb", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd3, 8'hFF});
        step();
        chk("dec_zero", flag_zero, 1'b0);
        wait_halt("halt2", 20);
        chk("inc_wrap", {rf[3], flag_zero, pc}, {8'h00, 1'b1, 8'd6});

        // SWAP r1,r2 then NOP
        set_reg(3'd1, 8'h11);
        set_reg(3'd2, 8'h22);
        pulse_start();
        step(3);
        chk("swap_wb", {state, rf_we, rf_waddr, rf_wdata}, {3'd4, 1'b1, 3'd1, 8'h22});
        step();
        chk("swap_wb2", {state, rf_we, rf_waddr, rf_wdata}, {3'd5, 1'b1, 3'd2, 8'h11});
        step();
        chk("swap_regs", {state, rf[1], rf[2], flag_zero}, {3'd1, 8'h22, 8'h11, 1'b0});
        step(2);
        chk("nop_2cyc", {state, pc}, {3'd1, 8'd8});
        wait_halt("halt3", 20);
        chk("halt3_pc", pc, 8'd9);

        // fetch timeout at pc 9
        ack_en = 1'b0;
        pulse_start();
        step(T - 1);
        chk("to_waiting", {state, imem_req, pc}, {3'd1, 1'b1, 8'd9});
        step();
        chk("to_fault", {state, fault, halted, pc}, {3'd6, 1'b1, 1'b1, 8'd9});
        ack_en = 1'b1;
        pulse_start();
        chk("to_resume", {state, fault, imem_addr}, {3'd1, 1'b0, 8'd9});
        wait_halt("halt4", 20);
        chk("halt4_pc", {pc, fault}, {8'd10, 1'b0});

        // NOP run to HALT at 255, pc wraps
        pulse_start();
        wait_halt("halt_wrap", 1000);
        chk("pc_wrap", {pc, halted, fault}, {8'd0, 1'b1, 1'b0});

        // async reset in the middle of ADD write-back
        set_reg(3'd0, 8'd5);
        set_reg(3'd1, 8'd3);
        pulse_start();
        step(3);
        chk("mid_wb", {state, rf_we}, {3'd4, 1'b1});
        rst = 1'b1;
        #1;
        chk("rst_async", {state, rf_we, busy, pc}, {3'd0, 1'b0, 1'b0, 8'd0});
        step();
        chk("rst_nowb", {state, rf_we, pc, rf[0]}, {3'd0, 1'b0, 8'd0, 8'd5});
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16: maximum FETCH wait cycles for imem_ack before a fault.
REQ-002 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); reset rst is asynchronous, active-high; clock clk.
REQ-003 SHALL have ports start (in, 1, begin or resume execution) and imem_req (out, 1, fetch request).
REQ-004 SHALL have ports imem_addr (out, 8, fetch address, equals pc) and imem_ack (in, 1, fetch data valid).
REQ-005 SHALL have ports imem_data (in, 8, instruction word) and rf_raddr_a/rf_raddr_b (out, 3 each, register-file read addresses).
REQ-006 SHALL have ports rf_rdata_a/rf_rdata_b (in, 8 each, combinational register-file read data).
REQ-007 SHALL have ports alu_op (out, 2, 00=ADD 01=SUB 1x=reserved), alu_a/alu_b (out, 8 each) and alu_y (in, 8, combinational ALU result).
REQ-008 SHALL have ports rf_we (out, 1), rf_waddr (out, 3) and rf_wdata (out, 8) for register write-back.
REQ-009 SHALL have ports pc (out, 8), state (out, 3), flag_zero (out, 1), halted (out, 1), fault (out, 1) and busy (out, 1).

Function
REQ-010 SHALL decode the instruction register ir as [7:6]=opcode, [5:3]=ra, [2:0]=rb; opcode 01=ADD ra<=ra+rb, 10=SUB ra<=ra-rb, 11=SWAP ra<->rb.
REQ-011 SHALL decode opcode 00 by rb: 000=HALT, 001=INC ra, 010=DEC ra, 011=CLR ra, 100-111=NOP.
REQ-012 SHALL use state encoding IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, WB2=5, HALT=6, driven on the state output.
REQ-013 IDLE: SHALL go to FETCH on start=1 and hold otherwise.
REQ-014 FETCH: SHALL assert imem_req=1 with imem_addr=pc; on imem_ack=1 SHALL latch ir<=imem_data, set pc<=pc+1 (255 wraps to 0), clear the wait counter and go to DECODE.
REQ-015 FETCH timeout: SHALL count cycles without ack; when the count reaches ACK_TIMEOUT with no ack, SHALL go to HALT with fault<=1 and pc unchanged.
REQ-016 DECODE: rf_raddr_a=ir[5:3] and rf_raddr_b=ir[2:0] SHALL be driven continuously from ir in every state; in DECODE the block SHALL latch opa<=rf_rdata_a, opb<=rf_rdata_b.
REQ-017 DECODE: HALT SHALL go to HALT; NOP SHALL go to FETCH; all others SHALL go to EXEC.
REQ-018 EXEC: SHALL drive alu_a=opa and set res<=alu_y, then go to WB; ADD uses alu_op=00, alu_b=opb; SUB uses 01, opb; INC uses 00, 8'h01; DEC uses 01, 8'h01.
REQ-019 EXEC for CLR SHALL set res<=0 and for SWAP SHALL set res<=opb, with ALU outputs don't-care.
REQ-020 alu_op, alu_a and alu_b SHALL be 0 outside EXEC.
REQ-021 WB: SHALL assert rf_we=1 for exactly one cycle with rf_waddr=ra and rf_wdata=res, and SHALL set flag_zero<=(res==0); SWAP then goes to WB2, all others to FETCH.
REQ-022 WB2: SHALL assert rf_we=1 with rf_waddr=rb and rf_wdata=opa, then go to FETCH; flag_zero SHALL be unchanged.
REQ-023 SWAP with ra==rb SHALL still perform both writes (net no change).
REQ-024 Arithmetic SHALL be modulo 256, with overflow and borrow discarded.
REQ-025 HALT: SHALL hold halted=1; start=1 SHALL clear fault and halted and go to FETCH at the current pc.
REQ-026 imem_ack outside FETCH and start outside IDLE/HALT SHALL be ignored.
REQ-027 busy SHALL be 1 in every state except IDLE and HALT.
REQ-028 Latency SHALL be FETCH+DECODE+EXEC+WB = 4 cycles for ADD/SUB/INC/DEC/CLR with same-cycle ack, 5 for SWAP and 2 for NOP; each ack wait cycle adds one.

Reset
REQ-029 On rst, SHALL enter IDLE immediately from any state, including mid-fetch and mid-write-back.
REQ-030 On rst, pc, ir, opa, opb, res, the wait counter, flag_zero, halted, fault and busy SHALL all be 0.
REQ-031 On rst, imem_req, rf_we, alu_op, alu_a, alu_b, rf_waddr and rf_wdata SHALL all be 0.
REQ-032 No write-back SHALL occur in the cycle rst is asserted.

Verification
REQ-033 Program {0x41 ADD r0,r1} with r0=5, r1=3, immediate ack, start pulse -> WB writes r0=8 on cycle 4 after start, flag_zero=0, pc=1.
REQ-034 SUB r2,r2 with r2=7 -> rf_wdata=0 and flag_zero=1; DEC on a register holding 0 -> writes 0xFF and flag_zero=0.
REQ-035 SWAP r1,r2 (0xCA) with r1=0x11, r2=0x22 -> WB writes r1=0x22, WB2 writes r2=0x11 in consecutive cycles, 5 cycles total.
REQ-036 imem_ack held low for ACK_TIMEOUT cycles -> state=HALT, fault=1, pc unchanged; start -> FETCH at the same pc with fault=0.
REQ-037 HALT instruction at address 255 -> pc wraps to 0 and halted=1; rst asserted during WB of an ADD -> next cycle state=IDLE, rf_we=0, pc=0.
